// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller: FSM state encoding,
// default widths and the branch-target table index width.
package pc_ctrl_pkg;

  // Default program-counter / branch-target width in bits
  localparam int D_DEFAULT = 10;

  // Default branch-target table depth
  localparam int N_TGT_DEFAULT = 16;

  // Table index width is fixed at 4 bits regardless of depth
  localparam int IDX_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Bundle of control, branch, table-configuration and status signals for the
// program-counter controller. The master side drives instruction-decode and
// configuration inputs; the slave side is the controller itself.
interface pc_ctrl_if
  import pc_ctrl_pkg::*;
#(
  parameter int D = D_DEFAULT
);

  logic             start;
  logic             halt;
  logic             stall;
  logic             br_en;
  logic             br_taken;
  logic             br_rel;
  logic [IDX_W-1:0] br_idx;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [D-1:0]     cfg_data;
  logic [D-1:0]     prog_ctr;
  logic             running;
  logic             done;

  modport master (
    output start, halt, stall, br_en, br_taken, br_rel, br_idx,
    output cfg_we, cfg_addr, cfg_data,
    input  prog_ctr, running, done
  );

  modport slave (
    input  start, halt, stall, br_en, br_taken, br_rel, br_idx,
    input  cfg_we, cfg_addr, cfg_data,
    output prog_ctr, running, done
  );

endinterface

// File: rtl/branch_tgt_table.sv
// Branch-target table: one registered write port, one combinational read
// port. Entries hold either absolute targets or signed PC-relative offsets;
// the interpretation belongs to the reader. Reset clears every entry.
module branch_tgt_table
  import pc_ctrl_pkg::*;
#(
  parameter int D     = D_DEFAULT,
  parameter int N_TGT = N_TGT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [D-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [D-1:0]     rdata
);

  logic [D-1:0] mem [N_TGT];

  // Write port: clear on reset, otherwise store on the strobe; out-of-range
  // indices (only possible for a shallow table) are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TGT; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < N_TGT)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is combinational, so a same-cycle write is not yet visible
  assign rdata = (int'(raddr) < N_TGT) ? mem[raddr] : '0;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: IDLE/RUN/HALT state machine, PC register and
// next-PC adder/mux. Branch targets come from the branch_tgt_table sub-module.
// All outputs are registered.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int D     = D_DEFAULT,
  parameter int N_TGT = N_TGT_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  pc_ctrl_if.slave bus
);

  state_t       state;
  logic [D-1:0] pc_q;
  logic         running_q;
  logic         done_q;

  logic [D-1:0] tgt_entry;
  logic [D-1:0] pc_inc;
  logic [D-1:0] br_target;

  branch_tgt_table #(
    .D     (D),
    .N_TGT (N_TGT)
  ) u_tbl (
    .clk   (clk),
    .reset (reset),
    .we    (bus.cfg_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (bus.br_idx),
    .rdata (tgt_entry)
  );

  // Next-PC candidates; D-bit addition wraps naturally, which also makes a
  // two's-complement relative entry act as a signed offset.
  always_comb begin
    pc_inc    = pc_q + D'(1);
    br_target = tgt_entry;
    if (bus.br_rel) begin
      br_target = pc_q + tgt_entry;
    end
  end

  // Controller FSM with registered PC and status flags; in RUN the priority
  // is halt, then stall, then a taken branch, then increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc_q <= '0;
          if (bus.start) begin
            state     <= RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.halt) begin
            state     <= HALT;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (bus.stall) begin
            pc_q <= pc_q;
          end else if (bus.br_en && bus.br_taken) begin
            pc_q <= br_target;
          end else begin
            pc_q <= pc_inc;
          end
        end
        HALT: begin
          if (bus.start) begin
            state     <= RUN;
            pc_q      <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          pc_q      <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;

endmodule
